// File: rtl/fp_result_serializer.sv
// Parallel-to-serial output stage for the FP adder result word.
// Optional trailing even-parity bit is enabled by defining SERIAL_PARITY_EN.
module fp_result_serializer #(
   parameter int unsigned WIDTH     = 32,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             en_in,
   input  logic             load_in,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             rd_in,
   output logic             serial_out,
   output logic             serial_valid_out,
   output logic             output_rdy,
   output logic             done_out,
   output logic             overrun_out
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef SERIAL_PARITY_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_count;
   logic             r_overrun;
   logic             w_load;
   logic             w_accept;
   logic             w_head;
`ifdef SERIAL_PARITY_EN
   logic             r_parity;
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_accept    = 1'b0;
      if (en_in) begin
         case (r_state)
            S_IDLE: begin
               if (load_in) begin
                  w_load      = 1'b1;
                  w_state_nxt = S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (rd_in) begin
                  w_accept = 1'b1;
                  if (r_count == LAST_IDX) begin
`ifdef SERIAL_PARITY_EN
                     w_state_nxt = S_PARITY;
`else
                     w_state_nxt = S_DONE;
`endif
                  end
               end
            end
`ifdef SERIAL_PARITY_EN
            S_PARITY: begin
               if (rd_in) begin
                  w_state_nxt = S_DONE;
               end
            end
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_shift   <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
`ifdef SERIAL_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         if (w_load) begin
            r_shift  <= parallel_in;
            r_count  <= '0;
`ifdef SERIAL_PARITY_EN
            r_parity <= ^parallel_in;
`endif
         end else if (w_accept) begin
            // zero fill leaves the register clear once the word has drained
            r_shift <= LSB_FIRST ? {1'b0, r_shift[WIDTH-1:1]}
                                 : {r_shift[WIDTH-2:0], 1'b0};
            r_count <= r_count + CW'(1);
         end
         if (en_in && load_in && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign w_head = LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1];

`ifdef SERIAL_PARITY_EN
   assign serial_out       = (r_state == S_PARITY) ? r_parity : w_head;
   assign serial_valid_out = en_in && ((r_state == S_SHIFT) || (r_state == S_PARITY));
`else
   assign serial_out       = w_head;
   assign serial_valid_out = en_in && (r_state == S_SHIFT);
`endif
   assign output_rdy  = (r_state == S_IDLE);
   assign done_out    = en_in && (r_state == S_DONE);
   assign overrun_out = r_overrun;

endmodule

// File: tb/tb_fp_result_serializer.sv
// Scoreboard bench for fp_result_serializer: stimulus pushes expected bits/words,
// a negedge monitor pops and compares every accepted bit and every done pulse.
module tb_fp_result_serializer;

   localparam int unsigned W = 32;
`ifdef SERIAL_PARITY_EN
   localparam int unsigned PEXTRA = 1;
`else
   localparam int unsigned PEXTRA = 0;
`endif

   logic          clk_in = 1'b0;
   logic          rst_n_in = 1'b0;
   logic          en_in = 1'b1;
   logic          load_in = 1'b0;
   logic [W-1:0]  parallel_in = '0;
   logic          rd_in = 1'b0;
   logic          serial_out;
   logic          serial_valid_out;
   logic          output_rdy;
   logic          done_out;
   logic          overrun_out;

   int unsigned   tests = 0;
   int unsigned   fails = 0;

   logic          q_bits[$];
   logic [W-1:0]  q_words[$];

   logic [W-1:0]  mon_asm = '0;
   int unsigned   mon_nbits = 0;
   logic          mon_prev_stall = 1'b0;
   logic          mon_prev_bit = 1'b0;

   fp_result_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
      .clk_in           (clk_in),
      .rst_n_in         (rst_n_in),
      .en_in            (en_in),
      .load_in          (load_in),
      .parallel_in      (parallel_in),
      .rd_in            (rd_in),
      .serial_out       (serial_out),
      .serial_valid_out (serial_valid_out),
      .output_rdy       (output_rdy),
      .done_out         (done_out),
      .overrun_out      (overrun_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Reference model: LSB-first bit list of the word, then optional even parity.
   task automatic model_push(input logic [W-1:0] w);
      for (int i = 0; i < int'(W); i++) q_bits.push_back(((w >> i) & 1) != 0);
      if (PEXTRA != 0) q_bits.push_back((($countones(w)) % 2) == 1);
      q_words.push_back(w);
   endtask

   task automatic wait_rdy();
      int unsigned n = 0;
      while (output_rdy !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      if (output_rdy !== 1'b1) check("rdy_timeout", 32'd0, 32'd1);
   endtask

   task automatic load_word(input logic [W-1:0] w);
      wait_rdy();
      load_in = 1'b1;
      parallel_in = w;
      model_push(w);
      tick();
      load_in = 1'b0;
      parallel_in = $urandom;
   endtask

   task automatic wait_done(input bit random_rd, output int unsigned cycles);
      cycles = 1;
      while (done_out !== 1'b1 && cycles < 400) begin
         if (random_rd) begin
            rd_in = ($urandom % 4) != 0;
            en_in = ($urandom % 8) != 0;
         end
         tick();
         cycles++;
      end
      if (done_out !== 1'b1) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset_midcycle();
      @(posedge clk_in);
      #3;
      rst_n_in = 1'b0;
      q_bits.delete();
      q_words.delete();
      #1;
      check("rst_rdy", 32'(output_rdy), 32'd1);
      check("rst_valid", 32'(serial_valid_out), 32'd0);
      check("rst_overrun", 32'(overrun_out), 32'd0);
      check("rst_done", 32'(done_out), 32'd0);
      check("rst_serial", 32'(serial_out), 32'd0);
      tick();
      tick();
      rst_n_in = 1'b1;
      tick();
   endtask

   always @(negedge clk_in) begin
      if (!rst_n_in) begin
         mon_asm = '0;
         mon_nbits = 0;
         mon_prev_stall = 1'b0;
      end else if (!en_in) begin
         check("gap_valid", 32'(serial_valid_out), 32'd0);
         check("gap_done", 32'(done_out), 32'd0);
      end else begin
         if (serial_valid_out === 1'b1) begin
            if (mon_prev_stall) check("stall_hold", 32'(serial_out), 32'(mon_prev_bit));
            if (rd_in) begin
               if (q_bits.size() == 0) begin
                  check("unexpected_bit", 32'd1, 32'd0);
               end else begin
                  check("serial_bit", 32'(serial_out), 32'(q_bits.pop_front()));
               end
               if (mon_nbits < W) mon_asm = {serial_out, mon_asm[W-1:1]};
               mon_nbits++;
            end
         end
         mon_prev_stall = (serial_valid_out === 1'b1) && !rd_in;
         mon_prev_bit = serial_out;
         if (done_out === 1'b1) begin
            check("done_bitcount", 32'(mon_nbits), 32'(W + PEXTRA));
            check("done_queue_empty", 32'(q_bits.size()), 32'd0);
            if (q_words.size() == 0) begin
               check("spurious_done", 32'd1, 32'd0);
            end else begin
               check("word_capture", mon_asm, q_words.pop_front());
            end
            mon_nbits = 0;
            mon_asm = '0;
         end
      end
   end

   initial begin
      int unsigned cyc;

      rst_n_in = 1'b0;
      #1;
      check("init_rdy", 32'(output_rdy), 32'd1);
      check("init_valid", 32'(serial_valid_out), 32'd0);
      tick();
      tick();
      rst_n_in = 1'b1;
      tick();

      // Single word with rd_in held high: exact cycle timing
      rd_in = 1'b1;
      load_word(32'h3F80_0000);
      check("c1_rdy", 32'(output_rdy), 32'd0);
      check("c1_valid", 32'(serial_valid_out), 32'd1);
      wait_done(1'b0, cyc);
      check("done_cycle", 32'(cyc), 32'(W + 1 + PEXTRA));
      check("done_rdy", 32'(output_rdy), 32'd0);
      tick();
      check("post_done_rdy", 32'(output_rdy), 32'd1);
      check("done_single", 32'(done_out), 32'd0);

      // Stalls: rd_in toggles every cycle
      load_word(32'hA5A5_A5A5);
      for (int i = 0; i < 2 * int'(W + PEXTRA) + 4 && done_out !== 1'b1; i++) begin
         rd_in = ~rd_in;
         tick();
      end
      check("stall_done", 32'(done_out), 32'd1);
      tick();
      check("stall_done_single", 32'(done_out), 32'd0);

      // Enable gap of 10 cycles at bit 16
      rd_in = 1'b1;
      load_word(32'hC0FF_EE11);
      for (int i = 0; i < 16; i++) tick();
      en_in = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("gap_state_kept", 32'(output_rdy), 32'd0);
      en_in = 1'b1;
      wait_done(1'b0, cyc);
      check("gap_done_cycle", 32'(cyc), 32'(W + 1 + PEXTRA - 16));
      tick();

      // Overrun: second load while busy is ignored
      load_word(32'h1234_5678);
      for (int i = 0; i < 4; i++) tick();
      load_in = 1'b1;
      parallel_in = '1;
      tick();
      load_in = 1'b0;
      check("overrun_set", 32'(overrun_out), 32'd1);
      wait_done(1'b0, cyc);
      tick();
      check("overrun_sticky", 32'(overrun_out), 32'd1);

      // Asynchronous reset in the middle of a word
      load_word(32'hDEAD_BEEF);
      for (int i = 0; i < 10; i++) tick();
      do_reset_midcycle();
      check("post_reset_rdy", 32'(output_rdy), 32'd1);

      // Load coinciding with the final accepted bit
      load_word(32'h0F0F_1234);
      for (int i = 0; i < int'(W) - 1; i++) tick();
      load_in = 1'b1;
      parallel_in = $urandom;
      tick();
      load_in = 1'b0;
      check("final_rd_overrun", 32'(overrun_out), 32'd1);
      check("final_rd_done", 32'(done_out), 32'(PEXTRA == 0));
      wait_done(1'b0, cyc);
      tick();

`ifdef SERIAL_PARITY_EN
      load_word(32'h0000_0007);
      wait_done(1'b0, cyc);
      check("parity7_done_cycle", 32'(cyc), 32'(W + 2));
      tick();
      load_word(32'h0000_0003);
      wait_done(1'b0, cyc);
      tick();
`endif

      // Randomized words with random rd_in and enable drops
      for (int n = 0; n < 8; n++) begin
         en_in = 1'b1;
         load_word($urandom);
         wait_done(1'b1, cyc);
         en_in = 1'b1;
         tick();
      end
      rd_in = 1'b0;
      tick();
      tick();
      check("words_outstanding", 32'(q_words.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
